// File: rtl/reloj_bus_param_pkg.sv
// Shared definitions for the BCD clock: digit-select codes, digit limits and 12 h mapping.
package reloj_bus_param_pkg;

  typedef enum logic [2:0] {
    DIR_US     = 3'd0,
    DIR_DS     = 3'd1,
    DIR_UM     = 3'd2,
    DIR_DM     = 3'd3,
    DIR_UH     = 3'd4,
    DIR_DH     = 3'd5,
    DIR_ALM_UM = 3'd6,
    DIR_ALM_DM = 3'd7
  } dir_t;

  localparam logic [3:0] LIM_UNIDADES = 4'd9;
  localparam logic [3:0] LIM_DECENAS  = 4'd5;
  localparam logic [4:0] LIM_HORA     = 5'd23;
  localparam logic [4:0] HORA_12      = 5'd12;

  // 24 h binary hour to 12 h display hour: 0 shows as 12, 13..23 fold to 1..11.
  function automatic logic [4:0] hora_12(input logic [4:0] h24);
    if (h24 == 5'd0) begin
      return HORA_12;
    end else if (h24 > HORA_12) begin
      return h24 - HORA_12;
    end else begin
      return h24;
    end
  endfunction

endpackage

// File: rtl/contador_bcd.sv
// Single BCD digit that counts 0..MAX_VAL on carry-in and can be loaded directly.
module contador_bcd #(
  parameter logic [3:0] MAX_VAL = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cin,
  input  logic       load,
  input  logic [3:0] dato,
  output logic [3:0] q,
  output logic       cout
);

  assign cout = cin && (q == MAX_VAL);

  // Load has priority over counting; counting wraps back to zero after MAX_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (load) begin
      q <= dato;
    end else if (cin) begin
      q <= (q == MAX_VAL) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/reloj_bus_param.sv
// 24 h BCD clock with prescaler, digit load/readback bus, 12 h view, day and alarm pulses.
module reloj_bus_param #(
  parameter int unsigned TICK_DIV = 1,
  parameter bit          ALARM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       modo12,
  input  logic [2:0] direccion,
  input  logic       load,
  input  logic [3:0] load_dato,
  input  logic [4:0] alarma_hora,
  output logic [3:0] BUS,
  output logic       pm,
  output logic       dia,
  output logic       alarma
);
  import reloj_bus_param_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          inc;
  logic          ticked;
  logic          ld_ok;
  logic          wr;
  logic          time_wr;
  logic [3:0]    us, ds, um, dm, uh, dh, alm_um, alm_dm;
  logic          c_us, c_ds, c_um, c_dm;
  logic [1:0]    alm_cout_unused;
  logic [4:0]    hora_bin;
  logic [4:0]    hora_disp;
  logic [3:0]    dh_disp, uh_disp;
  logic [3:0]    bus_sel;

  assign tick     = en && (pre == PRE_MAX);
  assign wr       = load && ld_ok;
  assign time_wr  = wr && (direccion != DIR_ALM_UM) && (direccion != DIR_ALM_DM);
  assign inc      = tick && !time_wr;
  assign hora_bin = 5'(dh) * 5'd10 + 5'(uh);
  assign pm       = (hora_bin >= HORA_12);

  // Legality of the value offered on load_dato for the currently selected digit.
  always_comb begin
    ld_ok = 1'b0;
    case (dir_t'(direccion))
      DIR_US, DIR_UM, DIR_ALM_UM: ld_ok = (load_dato <= LIM_UNIDADES);
      DIR_DS, DIR_DM, DIR_ALM_DM: ld_ok = (load_dato <= LIM_DECENAS);
      DIR_UH: ld_ok = (load_dato <= LIM_UNIDADES) &&
                      ((8'(dh) * 8'd10 + 8'(load_dato)) <= 8'(LIM_HORA));
      DIR_DH: ld_ok = ((8'(load_dato) * 8'd10 + 8'(uh)) <= 8'(LIM_HORA));
      default: ld_ok = 1'b0;
    endcase
  end

  // Prescaler: restarts on any accepted time load so the next second is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (time_wr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  // Remembers that the current time was reached by counting, not by loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticked <= 1'b0;
    end else begin
      ticked <= inc;
    end
  end

  contador_bcd #(.MAX_VAL(LIM_UNIDADES)) u_us (
    .clk(clk), .rst_n(rst_n), .cin(inc), .load(wr && direccion == DIR_US),
    .dato(load_dato), .q(us), .cout(c_us));

  contador_bcd #(.MAX_VAL(LIM_DECENAS)) u_ds (
    .clk(clk), .rst_n(rst_n), .cin(c_us), .load(wr && direccion == DIR_DS),
    .dato(load_dato), .q(ds), .cout(c_ds));

  contador_bcd #(.MAX_VAL(LIM_UNIDADES)) u_um (
    .clk(clk), .rst_n(rst_n), .cin(c_ds), .load(wr && direccion == DIR_UM),
    .dato(load_dato), .q(um), .cout(c_um));

  contador_bcd #(.MAX_VAL(LIM_DECENAS)) u_dm (
    .clk(clk), .rst_n(rst_n), .cin(c_um), .load(wr && direccion == DIR_DM),
    .dato(load_dato), .q(dm), .cout(c_dm));

  contador_bcd #(.MAX_VAL(LIM_UNIDADES)) u_alm_um (
    .clk(clk), .rst_n(rst_n), .cin(1'b0), .load(wr && direccion == DIR_ALM_UM),
    .dato(load_dato), .q(alm_um), .cout(alm_cout_unused[0]));

  contador_bcd #(.MAX_VAL(LIM_DECENAS)) u_alm_dm (
    .clk(clk), .rst_n(rst_n), .cin(1'b0), .load(wr && direccion == DIR_ALM_DM),
    .dato(load_dato), .q(alm_dm), .cout(alm_cout_unused[1]));

  // Hour pair: Uh runs 0..9 except under Dh=2 where 23 wraps to 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uh <= 4'd0;
      dh <= 4'd0;
    end else if (wr && direccion == DIR_UH) begin
      uh <= load_dato;
    end else if (wr && direccion == DIR_DH) begin
      dh <= load_dato;
    end else if (c_dm) begin
      if (hora_bin == LIM_HORA) begin
        uh <= 4'd0;
        dh <= 4'd0;
      end else if (uh == LIM_UNIDADES) begin
        uh <= 4'd0;
        dh <= dh + 4'd1;
      end else begin
        uh <= uh + 4'd1;
      end
    end
  end

  // Hour digits as presented on the bus, folded to 12 h when requested.
  always_comb begin
    hora_disp = modo12 ? hora_12(hora_bin) : hora_bin;
    if (hora_disp >= 5'd20) begin
      dh_disp = 4'd2;
    end else if (hora_disp >= 5'd10) begin
      dh_disp = 4'd1;
    end else begin
      dh_disp = 4'd0;
    end
    uh_disp = 4'(hora_disp - 5'(dh_disp) * 5'd10);
  end

  // Read mux for the digit selected by direccion.
  always_comb begin
    bus_sel = 4'd0;
    case (dir_t'(direccion))
      DIR_US:     bus_sel = us;
      DIR_DS:     bus_sel = ds;
      DIR_UM:     bus_sel = um;
      DIR_DM:     bus_sel = dm;
      DIR_UH:     bus_sel = uh_disp;
      DIR_DH:     bus_sel = dh_disp;
      DIR_ALM_UM: bus_sel = alm_um;
      DIR_ALM_DM: bus_sel = alm_dm;
      default:    bus_sel = 4'd0;
    endcase
  end

  // The 12 h view of hour 00 is nonzero, so the bus is forced low while reset is held.
  assign BUS = rst_n ? bus_sel : 4'd0;
  assign dia = ticked && (hora_bin == 5'd0) && (dm == 4'd0) && (um == 4'd0) &&
               (ds == 4'd0) && (us == 4'd0);

  generate
    if (ALARM_EN) begin : g_alarm
      assign alarma = ticked && (alarma_hora <= LIM_HORA) && (hora_bin == alarma_hora) &&
                      (dm == alm_dm) && (um == alm_um) && (ds == 4'd0) && (us == 4'd0);
    end else begin : g_no_alarm
      assign alarma = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_reloj_bus_param.sv
// Self-checking bench: two clocks (TICK_DIV 1 and 4) against a seconds-of-day model.
module tb_reloj_bus_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       modo12 = 1'b0;
  logic       load = 1'b0;
  logic [2:0] direccion = 3'd0;
  logic [3:0] load_dato = 4'd0;
  logic [4:0] alarma_hora = 5'd31;

  logic [3:0] bus1, bus4;
  logic       pm1, pm4, dia1, dia4, al1, al4;

  int checks = 0;
  int errors = 0;

  // Model state per instance: time as seconds of day, prescaler count, alarm minutes.
  int m_secs[2];
  int m_pre[2];
  int m_alm[2];
  bit m_ticked[2];
  int divs[2] = '{1, 4};

  always #5 clk = ~clk;

  reloj_bus_param #(.TICK_DIV(1), .ALARM_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .modo12(modo12), .direccion(direccion),
    .load(load), .load_dato(load_dato), .alarma_hora(alarma_hora),
    .BUS(bus1), .pm(pm1), .dia(dia1), .alarma(al1));

  reloj_bus_param #(.TICK_DIV(4), .ALARM_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .modo12(modo12), .direccion(direccion),
    .load(load), .load_dato(load_dato), .alarma_hora(alarma_hora),
    .BUS(bus4), .pm(pm4), .dia(dia4), .alarma(al4));

  task automatic checkOutput(input string name, input int k, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s div=%0d got %0d expected %0d at %0t", name, divs[k], actual, expected, $time);
    end
  endtask

  // One clock edge of the model: accepted time loads replace the time, otherwise the
  // prescaler runs and every TICK_DIV-th enabled cycle adds one second.
  task automatic modelStep(input int k);
    int h, m, s, nh, v;
    bit time_ok;
    h = m_secs[k] / 3600;
    m = (m_secs[k] / 60) % 60;
    s = m_secs[k] % 60;
    v = int'(load_dato);
    time_ok = 1'b0;
    if (load) begin
      case (direccion)
        3'd0: if (v <= 9) begin s = (s / 10) * 10 + v; time_ok = 1'b1; end
        3'd1: if (v <= 5) begin s = v * 10 + s % 10; time_ok = 1'b1; end
        3'd2: if (v <= 9) begin m = (m / 10) * 10 + v; time_ok = 1'b1; end
        3'd3: if (v <= 5) begin m = v * 10 + m % 10; time_ok = 1'b1; end
        3'd4: begin
          nh = (h / 10) * 10 + v;
          if (v <= 9 && nh <= 23) begin h = nh; time_ok = 1'b1; end
        end
        3'd5: begin
          nh = v * 10 + h % 10;
          if (nh <= 23) begin h = nh; time_ok = 1'b1; end
        end
        3'd6: if (v <= 9) m_alm[k] = (m_alm[k] / 10) * 10 + v;
        default: if (v <= 5) m_alm[k] = v * 10 + m_alm[k] % 10;
      endcase
    end
    if (time_ok) begin
      m_secs[k] = h * 3600 + m * 60 + s;
      m_pre[k] = 0;
      m_ticked[k] = 1'b0;
    end else if (en) begin
      if (m_pre[k] == divs[k] - 1) begin
        m_pre[k] = 0;
        m_secs[k] = (m_secs[k] + 1) % 86400;
        m_ticked[k] = 1'b1;
      end else begin
        m_pre[k] = m_pre[k] + 1;
        m_ticked[k] = 1'b0;
      end
    end else begin
      m_ticked[k] = 1'b0;
    end
  endtask

  function automatic int expBus(input int k);
    int h, m, s, hd;
    if (!rst_n) return 0;
    h = m_secs[k] / 3600;
    m = (m_secs[k] / 60) % 60;
    s = m_secs[k] % 60;
    hd = h;
    if (modo12) hd = (h % 12 == 0) ? 12 : h % 12;
    case (direccion)
      3'd0: return s % 10;
      3'd1: return s / 10;
      3'd2: return m % 10;
      3'd3: return m / 10;
      3'd4: return hd % 10;
      3'd5: return hd / 10;
      3'd6: return m_alm[k] % 10;
      default: return m_alm[k] / 10;
    endcase
  endfunction

  function automatic int expAlarma(input int k);
    if (!m_ticked[k] || alarma_hora > 5'd23) return 0;
    return (m_secs[k] == int'(alarma_hora) * 3600 + m_alm[k] * 60) ? 1 : 0;
  endfunction

  // Reference model advances on the same edges as the designs, resets asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_secs[k] = 0;
        m_pre[k] = 0;
        m_alm[k] = 0;
        m_ticked[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) modelStep(k);
    end
  end

  // Every cycle, away from the active edge, both designs are compared with the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput("bus", k, int'(k == 0 ? bus1 : bus4), expBus(k));
      checkOutput("pm", k, int'(k == 0 ? pm1 : pm4), (rst_n && m_secs[k] >= 12 * 3600) ? 1 : 0);
      checkOutput("dia", k, int'(k == 0 ? dia1 : dia4), (m_ticked[k] && m_secs[k] == 0) ? 1 : 0);
      checkOutput("alarma", k, int'(k == 0 ? al1 : al4), expAlarma(k));
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Presents one load strobe for exactly one clock edge.
  task automatic applyStimulus(input logic [2:0] d, input logic [3:0] v);
    load = 1'b1;
    direccion = d;
    load_dato = v;
    nextCycle();
    load = 1'b0;
  endtask

  initial begin
    // Reset held with the 12 h hour-tens digit selected: bus must still read zero.
    rst_n = 1'b0;
    modo12 = 1'b1;
    direccion = 3'd5;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("rst_bus", 0, int'(bus1), 0);
    checkOutput("rst_bus", 1, int'(bus4), 0);
    checkOutput("rst_pm", 0, int'(pm1), 0);
    checkOutput("rst_dia", 0, int'(dia1), 0);
    checkOutput("rst_alarma", 0, int'(al1), 0);

    // Free run with TICK_DIV=1: seconds units step every cycle.
    nextCycle();
    rst_n = 1'b1;
    en = 1'b1;
    modo12 = 1'b0;
    direccion = 3'd0;
    for (int i = 0; i < 10; i++) begin
      #1 checkOutput("us_count", 0, int'(bus1), i);
      nextCycle();
    end
    direccion = 3'd1;
    #1 checkOutput("ds_at_10", 0, int'(bus1), 1);
    direccion = 3'd0;
    #1 checkOutput("us_div4_at_10", 1, int'(bus4), 2);
    for (int i = 0; i < 10; i++) begin
      #1 checkOutput("us_count2", 0, int'(bus1), i);
      nextCycle();
    end

    // Midnight rollover from a loaded 23:59:59.
    en = 1'b0;
    applyStimulus(3'd4, 4'd0);
    applyStimulus(3'd5, 4'd2);
    applyStimulus(3'd4, 4'd3);
    applyStimulus(3'd3, 4'd5);
    applyStimulus(3'd2, 4'd9);
    applyStimulus(3'd1, 4'd5);
    applyStimulus(3'd0, 4'd9);
    #1 checkOutput("pm_2359", 0, int'(pm1), 1);
    checkOutput("dia_on_load", 0, int'(dia1), 0);
    en = 1'b1;
    nextCycle();
    en = 1'b0;
    #1 checkOutput("dia_pulse", 0, int'(dia1), 1);
    checkOutput("pm_midnight", 0, int'(pm1), 0);
    checkOutput("us_midnight", 0, int'(bus1), 0);
    checkOutput("dia_div4_idle", 1, int'(dia4), 0);
    nextCycle();
    #1 checkOutput("dia_one_cycle", 0, int'(dia1), 0);

    // 12 h view of 00 and 13.
    modo12 = 1'b1;
    direccion = 3'd5;
    #1 checkOutput("h12_00_dh", 0, int'(bus1), 1);
    direccion = 3'd4;
    #1 checkOutput("h12_00_uh", 0, int'(bus1), 2);
    applyStimulus(3'd5, 4'd1);
    applyStimulus(3'd4, 4'd3);
    direccion = 3'd5;
    #1 checkOutput("h12_13_dh", 0, int'(bus1), 0);
    direccion = 3'd4;
    #1 checkOutput("h12_13_uh", 0, int'(bus1), 1);
    checkOutput("pm_13", 0, int'(pm1), 1);
    modo12 = 1'b0;

    // Illegal loads leave the time untouched.
    applyStimulus(3'd4, 4'd5);
    applyStimulus(3'd5, 4'd2);
    direccion = 3'd5;
    #1 checkOutput("dh_reject", 0, int'(bus1), 1);
    direccion = 3'd4;
    #1 checkOutput("uh_keep", 0, int'(bus1), 5);
    applyStimulus(3'd1, 4'd6);
    direccion = 3'd1;
    #1 checkOutput("ds_reject", 0, int'(bus1), 0);

    // TICK_DIV=4: a load landing on the tick suppresses that increment.
    applyStimulus(3'd0, 4'd3);
    en = 1'b1;
    direccion = 3'd0;
    repeat (3) nextCycle();
    applyStimulus(3'd0, 4'd5);
    #1 checkOutput("load_beats_tick", 1, int'(bus4), 5);
    repeat (3) nextCycle();
    #1 checkOutput("no_early_tick", 1, int'(bus4), 5);
    nextCycle();
    #1 checkOutput("tick_after_4", 1, int'(bus4), 6);
    en = 1'b0;

    // Alarm at 01:00 reached from 00:59:59.
    alarma_hora = 5'd1;
    applyStimulus(3'd6, 4'd0);
    applyStimulus(3'd7, 4'd0);
    applyStimulus(3'd5, 4'd0);
    applyStimulus(3'd4, 4'd0);
    applyStimulus(3'd3, 4'd5);
    applyStimulus(3'd2, 4'd9);
    applyStimulus(3'd1, 4'd5);
    applyStimulus(3'd0, 4'd9);
    en = 1'b1;
    nextCycle();
    en = 1'b0;
    #1 checkOutput("alarma_pulse", 0, int'(al1), 1);
    nextCycle();
    #1 checkOutput("alarma_one_cycle", 0, int'(al1), 0);

    // Reset mid-run clears everything immediately; first tick comes TICK_DIV cycles later.
    en = 1'b1;
    modo12 = 1'b1;
    direccion = 3'd5;
    repeat (5) nextCycle();
    rst_n = 1'b0;
    #1 checkOutput("midrst_bus", 0, int'(bus1), 0);
    checkOutput("midrst_bus", 1, int'(bus4), 0);
    checkOutput("midrst_pm", 0, int'(pm1), 0);
    nextCycle();
    rst_n = 1'b1;
    modo12 = 1'b0;
    direccion = 3'd0;
    repeat (3) nextCycle();
    #1 checkOutput("post_rst_wait", 1, int'(bus4), 0);
    nextCycle();
    #1 checkOutput("post_rst_tick", 1, int'(bus4), 1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 4000; c++) begin
      nextCycle();
      en = ($urandom_range(0, 9) != 0);
      modo12 = 1'($urandom_range(0, 1));
      direccion = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 7) == 0);
      load_dato = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) alarma_hora = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) alarma_hora = 5'(m_secs[0] / 3600);
    end
    load = 1'b0;
    nextCycle();
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reloj_bus_param.md
RELOJ_BUS_PARAM -- requirements
Module: reloj_bus_param

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, clk cycles per one-second tick (range 1..2^24).
REQ-002 SHALL have parameter ALARM_EN, default 1, 1 = alarm comparator present, 0 = alarma tied low.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes prescaler and time.
REQ-006 SHALL have port modo12  input  1  display mode; 0 = 24 h, 1 = 12 h.
REQ-007 SHALL have port direccion  input  3  digit select: 000 Us, 001 Ds, 010 Um, 011 Dm, 100 Uh, 101 Dh, 110 Um alarm, 111 Dm alarm.
REQ-008 SHALL have port load  input  1  write strobe for the digit selected by direccion.
REQ-009 SHALL have port load_dato  input  4  BCD value written on load.
REQ-010 SHALL have port alarma_hora  input  5  alarm hour, binary 0..23.
REQ-011 SHALL have port BUS  output  4  BCD digit selected by direccion.
REQ-012 SHALL have port pm  output  1  1 when internal hour >= 12.
REQ-013 SHALL have port dia  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.
REQ-014 SHALL have port alarma  output  1  one-cycle pulse when time reaches alarma_hora:alarm-minutes:00.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 while en=1 and assert internal tick in the cycle it holds TICK_DIV-1; TICK_DIV=1 gives tick every enabled cycle.
REQ-016 On tick, Us SHALL increment 0..9; on wrap, Ds increments 0..5; then Um 0..9; then Dm 0..5; then hour 00..23, all in the same cycle (registered, 1-cycle latency from tick).
REQ-017 Hours SHALL be stored internally as 24 h BCD (Dh 0..2, Uh 0..9, Dh=2 limits Uh to 0..3).
REQ-018 BUS SHALL be combinational from registered state and direccion, zero latency.
REQ-019 When modo12=1, hour digits on BUS SHALL map: 00 -> 12, 13..23 -> 01..11, 01..12 unchanged; internal state unaffected.
REQ-020 pm SHALL reflect the internal hour regardless of modo12.
REQ-021 With load=1, the selected digit SHALL be written at the next edge if load_dato is legal for that digit (Us/Um 0..9, Ds/Dm 0..5, resulting hour <= 23); an illegal value SHALL be ignored with no state change.
REQ-022 A legal load to 000..101 SHALL also clear the prescaler; load SHALL win over a simultaneous tick (no increment that cycle).
REQ-023 Loads to 110/111 SHALL write alarm-minute digits only and SHALL NOT disturb time or prescaler.
REQ-024 dia SHALL pulse exactly one cycle coincident with the registered 00:00:00 after 23:59:59 via tick; never on a load.
REQ-025 alarma SHALL pulse one cycle when the registered time first equals alarma_hora:alarm-minutes:00 via tick; a load matching the alarm SHALL NOT pulse.
REQ-026 alarma_hora > 23 SHALL never match.

Reset
REQ-027 rst_n=0 SHALL immediately clear prescaler, all six time digits, alarm-minute digits; BUS = 0 for any direccion, pm = 0, dia = 0, alarma = 0.
REQ-028 Reset asserted mid-count or mid-load SHALL take priority; first tick after release SHALL occur TICK_DIV enabled cycles later.

Structure
REQ-029 Shared package SHALL hold digit-select encodings (DIR_US..DIR_ALM_DM), digit limits (9, 5, 23) and the 12 h mapping constant.
REQ-030 Top SHALL instantiate one sub-module contador_bcd (parameterised modulus, load, carry-in, carry-out) for Us, Ds, Um, Dm, alarm digits; hour pair SHALL be handled in the top.

Verification
REQ-031 TICK_DIV=1, en=1 from reset, read 000 for 20 cycles -> BUS 0..9,0..9; at cycle 10 read 001 -> 1.
REQ-032 Load 23:59:5 then Us=9, one tick -> all digits 0, dia=1 for exactly one cycle, pm 1 -> 0.
REQ-033 modo12=1 at internal 00:xx -> Dh/Uh read 1/2; at 13:xx -> 0/1, pm=1.
REQ-034 Load Dh=2 while Uh=5 -> rejected, hour unchanged; load Ds=6 -> rejected.
REQ-035 TICK_DIV=4, load coincident with tick -> no increment; next increment 4 cycles after load.
REQ-036 alarma_hora=1, alarm minutes 00, time 00:59:59 -> one tick -> alarma one-cycle pulse; rst_n low mid-run -> all outputs 0 immediately.
